aes_round_ctrl: RTL and testbench

- Sequencer for an iterative AES-128 encryption engine. It replaces a fully unrolled combinational AES with one shared round unit that is reused over 10 cycles.
- Accepts a plaintext block and cipher key over a valid/ready handshake, then performs the initial AddRoundKey itself.
- Drives an external combinational round/key-expansion unit once per cycle and generates Rcon internally, so no Rcon inputs exist.
- Presents the ciphertext on an output valid/ready handshake with backpressure.

---
 rtl/aes_round_ctrl.sv | 144 ++++++++++++++
 tb/tb_aes_round_ctrl.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: sequencer for an iterative AES-128 encryption engine.
// Accepts a plaintext block and cipher key and performs the initial
// AddRoundKey itself. It then steps an external combinational
// round/key-expansion unit once per cycle for NR rounds and generates Rcon
// locally. The ciphertext is presented on a valid/ready output handshake.
// Optional feature: define AES_CTRL_ABORT_EN to add an 'abort' input. Abort
// drops the block in flight. Priority order is rst_n > abort > handshakes.
module aes_round_ctrl #(
    parameter int unsigned NR = 10,
    parameter int unsigned DW = 128
) (
    input  logic          clk,
    input  logic          rst_n,
`ifdef AES_CTRL_ABORT_EN
    input  logic          abort,
`endif
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_block,
    input  logic [DW-1:0] in_key,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_block,
    output logic          busy,
    output logic [3:0]    round_cnt,
    output logic [DW-1:0] rnd_state,
    output logic [DW-1:0] rnd_key,
    output logic [31:0]   rnd_rcon,
    output logic          rnd_last,
    input  logic [DW-1:0] rnd_next_state,
    input  logic [DW-1:0] rnd_next_key
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } fsm_e;

    localparam logic [3:0] LastRound = 4'(NR);

    fsm_e          fsm_q;
    logic [DW-1:0] state_q;
    logic [DW-1:0] key_q;
    logic [3:0]    round_q;
    logic [7:0]    rcon_q;
    logic          idle_q;
    logic          busy_q;
    logic          out_valid_q;
    logic          abort_w;

`ifdef AES_CTRL_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    // GF(2^8) multiply by x: produces the next Rcon byte.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Controller FSM with datapath registers and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q       <= StIdle;
            state_q     <= '0;
            key_q       <= '0;
            round_q     <= 4'd0;
            rcon_q      <= 8'h01;
            idle_q      <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (abort_w && (fsm_q != StIdle)) begin
            // Aborted block is dropped; it never reaches out_valid.
            fsm_q       <= StIdle;
            round_q     <= 4'd0;
            rcon_q      <= 8'h01;
            idle_q      <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (fsm_q)
                StIdle: begin
                    if (in_valid) begin
                        // Initial AddRoundKey happens on the accept edge.
                        state_q <= in_block ^ in_key;
                        key_q   <= in_key;
                        round_q <= 4'd1;
                        rcon_q  <= 8'h01;
                        fsm_q   <= StRun;
                        idle_q  <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                StRun: begin
                    state_q <= rnd_next_state;
                    key_q   <= rnd_next_key;
                    rcon_q  <= xtime(rcon_q);
                    if (round_q == LastRound) begin
                        fsm_q       <= StDone;
                        round_q     <= 4'd0;
                        out_valid_q <= 1'b1;
                    end else begin
                        round_q <= round_q + 4'd1;
                    end
                end
                StDone: begin
                    // state_q holds the ciphertext until it is taken.
                    if (out_ready) begin
                        fsm_q       <= StIdle;
                        rcon_q      <= 8'h01;
                        idle_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    fsm_q       <= StIdle;
                    round_q     <= 4'd0;
                    rcon_q      <= 8'h01;
                    idle_q      <= 1'b1;
                    busy_q      <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Outputs are driven straight from registers. in_ready is also gated by
    // rst_n so that it drops while reset is asserted.
    always_comb begin
        in_ready  = idle_q & rst_n;
        out_valid = out_valid_q;
        out_block = state_q;
        busy      = busy_q;
        round_cnt = round_q;
        rnd_state = state_q;
        rnd_key   = key_q;
        rnd_rcon  = {rcon_q, 24'h0};
        rnd_last  = (round_q == LastRound);
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: self-checking bench for aes_round_ctrl.
// It attaches a behavioural AES round/key-expansion unit to the rnd_* ports.
// It keeps a transaction-level model of the controller that is checked every
// cycle, and it runs directed FIPS-197 vectors with literal expectations.
// Build with +define+AES_CTRL_ABORT_EN to exercise the abort input.
module tb_aes_round_ctrl;

    localparam logic [127:0] AppBPt  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] AppBKey = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] AppBCt  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] AppCPt  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] AppCKey = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] AppCCt  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk;
    logic         rst_n;
    logic         abort;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_block;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_block;
    logic         busy;
    logic [3:0]   round_cnt;
    logic [127:0] rnd_state;
    logic [127:0] rnd_key;
    logic [31:0]  rnd_rcon;
    logic         rnd_last;
    logic [127:0] rnd_next_state;
    logic [127:0] rnd_next_key;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [7:0]   rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    logic [127:0] m_st [11];
    logic [127:0] m_k  [11];
    logic         m_busy = 1'b0;
    int           m_age  = 0;
    logic         armed  = 1'b0;
    logic [127:0] sunk [$];
    logic [7:0]   log_rcon [16];
    logic         log_last [16];
    int           log_n;

    aes_round_ctrl #(.NR(10), .DW(128)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
`ifdef AES_CTRL_ABORT_EN
        .abort          (abort),
`endif
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_block       (in_block),
        .in_key         (in_key),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_block      (out_block),
        .busy           (busy),
        .round_cnt      (round_cnt),
        .rnd_state      (rnd_state),
        .rnd_key        (rnd_key),
        .rnd_rcon       (rnd_rcon),
        .rnd_last       (rnd_last),
        .rnd_next_state (rnd_next_state),
        .rnd_next_key   (rnd_next_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- AES arithmetic ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: inverse as a^254, then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] inv, base, e;
        inv = 8'h01; base = a; e = 8'd254;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) inv = gmul(inv, base);
            base = gmul(base, base);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] expand_key(input logic [127:0] k, input logic [31:0] rc);
        logic [31:0] w3, t, n0, n1, n2, n3;
        w3 = k[31:0];
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ rc;
        n0 = k[127:96] ^ t;
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // Byte i of the block sits at bits [127-8i -: 8]; bytes fill columns first.
    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
        logic [127:0] sb, sr, mc;
        logic [7:0]   a0, a1, a2, a3;
        for (int i = 0; i < 16; i++) sb[8*(15-i) +: 8] = sbox(s[8*(15-i) +: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sr[8*(15-(4*c+r)) +: 8] = sb[8*(15-(4*((c+r)%4)+r)) +: 8];
        mc = sr;
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = sr[8*(15-4*c) +: 8];   a1 = sr[8*(14-4*c) +: 8];
                a2 = sr[8*(13-4*c) +: 8];   a3 = sr[8*(12-4*c) +: 8];
                mc[8*(15-4*c) +: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                mc[8*(14-4*c) +: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                mc[8*(13-4*c) +: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                mc[8*(12-4*c) +: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
        end
        return mc ^ k;
    endfunction

    // Full encryption; Rcon is regenerated by doubling rather than by table.
    function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input logic [127:0] key);
        logic [127:0] s, k;
        logic [7:0]   rc;
        s = pt ^ key; k = key; rc = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            k  = expand_key(k, {rc, 24'h0});
            s  = aes_round(s, k, r == 10);
            rc = gmul(rc, 8'h02);
        end
        return s;
    endfunction

    // External round unit attached to the controller.
    assign rnd_next_key   = expand_key(rnd_key, rnd_rcon);
    assign rnd_next_state = aes_round(rnd_state, rnd_next_key, rnd_last);

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got no event within the cycle bound, required one (t=%0t)",
                 name, $time);
    endtask

    // Intermediate states and round keys of a block, indexed by completed rounds.
    task automatic model_load(input logic [127:0] pt, input logic [127:0] key);
        m_st[0] = pt ^ key;
        m_k[0]  = key;
        for (int r = 1; r <= 10; r++) begin
            m_k[r]  = expand_key(m_k[r-1], {rcon_tab[r-1], 24'h0});
            m_st[r] = aes_round(m_st[r-1], m_k[r], r == 10);
        end
    endtask

    // Transaction model: m_age counts edges since accept (1..10 rounds, 11 done).
    initial begin : cmp_proc
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_busy = 1'b0; m_age = 0; armed = 1'b1;
            end else if (abort && m_busy) begin
                m_busy = 1'b0; m_age = 0;
            end else if (!m_busy) begin
                if (in_valid) begin
                    m_busy = 1'b1; m_age = 1;
                    model_load(in_block, in_key);
                end
            end else if (m_age < 11) begin
                m_age++;
            end else if (out_ready) begin
                m_busy = 1'b0; m_age = 0;
            end
            @(negedge clk);
            if (armed) begin
                chk("in_ready", 128'(in_ready), 128'(!m_busy && rst_n));
                chk("busy", 128'(busy), 128'(m_busy));
                chk("out_valid", 128'(out_valid), 128'(m_busy && m_age == 11));
                chk("round_cnt", 128'(round_cnt), 128'((m_busy && m_age <= 10) ? m_age : 0));
                chk("rnd_last", 128'(rnd_last), 128'(m_busy && m_age == 10));
                if (m_busy && m_age <= 10) begin
                    chk("rnd_rcon", 128'(rnd_rcon), 128'({rcon_tab[m_age-1], 24'h0}));
                    chk("rnd_state", rnd_state, m_st[m_age-1]);
                    chk("rnd_key", rnd_key, m_k[m_age-1]);
                end
                if (m_busy && m_age == 11) chk("out_block", out_block, m_st[10]);
            end
        end
    end

    // Sink: records every ciphertext actually handed over.
    always @(negedge clk) if (rst_n && out_valid && out_ready) sunk.push_back(out_block);

    // ---------------- stimulus tasks ----------------
    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
    endtask

    // Offers a block; returns 2 time units after the accept edge.
    task automatic send(input logic [127:0] pt, input logic [127:0] key, output int acc);
        bit ok;
        @(posedge clk); #2;
        in_valid = 1'b1; in_block = pt; in_key = key;
        wait_ready(ok);
        if (!ok) timeout("accept");
        @(posedge clk); #2;
        acc = cyc;
        in_valid = 1'b0;
        in_block = {$urandom, $urandom, $urandom, $urandom};
        in_key   = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Latency counts the accept edge itself, so a full run reports 11.
    task automatic wait_out(output logic [127:0] ct, output int lat);
        bit got;
        got = 1'b0; lat = 0; ct = '0; log_n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (out_valid) begin got = 1'b1; ct = out_block; break; end
            if (log_n < 16) begin
                log_rcon[log_n] = rnd_rcon[31:24];
                log_last[log_n] = rnd_last;
                log_n++;
            end
        end
        if (!got) timeout("out_valid");
    endtask

    task automatic wait_round(input logic [3:0] n);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (round_cnt == n) begin got = 1'b1; break; end
        end
        if (!got) timeout("round_cnt");
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin : main
        logic [127:0] ct;
        int           lat, acc, c0, c1;
        bit           ok;
        rst_n = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_block = '0; in_key = '0;

        // The model is checked against published vectors before it is trusted.
        chk("model_appB", aes_encrypt(AppBPt, AppBKey), AppBCt);
        chk("model_appC", aes_encrypt(AppCPt, AppCKey), AppCCt);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready_low", 128'(in_ready), 128'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_out_block", out_block, 128'd0);
        chk("rst_rnd_last", 128'(rnd_last), 128'd0);
        chk("rst_rnd_rcon", 128'(rnd_rcon), 128'h01000000);
        chk("rst_in_ready", 128'(in_ready), 128'd1);

        // App. B with out_ready held high.
        send(AppBPt, AppBKey, acc);
        wait_out(ct, lat);
        chk("appB_ct", ct, AppBCt);
        chk("appB_latency", 128'(lat), 128'd11);

        // App. C with a per-round Rcon / rnd_last log.
        send(AppCPt, AppCKey, acc);
        wait_out(ct, lat);
        chk("appC_ct", ct, AppCCt);
        chk("appC_latency", 128'(lat), 128'd11);
        chk("appC_rounds_logged", 128'(log_n), 128'd10);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("appC_rcon_r%0d", i + 1), 128'(log_rcon[i]), 128'(rcon_tab[i]));
            chk($sformatf("appC_last_r%0d", i + 1), 128'(log_last[i]), 128'(i == 9));
        end

        // Backpressure: hold off the consumer while another block is offered.
        @(posedge clk); #2;
        out_ready = 1'b0;
        sunk.delete();
        send(AppBPt, AppBKey, acc);
        wait_out(ct, lat);
        chk("bp_ct", ct, AppBCt);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #2;
            in_valid = 1'b1; in_block = AppCPt; in_key = AppCKey;
            @(negedge clk);
            chk("bp_out_valid", 128'(out_valid), 128'd1);
            chk("bp_out_block", out_block, AppBCt);
            chk("bp_in_ready", 128'(in_ready), 128'd0);
        end
        @(posedge clk); #2;
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_in_ready", 128'(in_ready), 128'd1);
        chk("bp_release_busy", 128'(busy), 128'd0);
        chk("bp_sunk_count", 128'(sunk.size()), 128'd1);
        if (sunk.size() > 0) chk("bp_sunk_ct", sunk[0], AppBCt);

        // Back-to-back with in_valid held high.
        sunk.delete();
        @(posedge clk); #2;
        in_valid = 1'b1; in_block = AppBPt; in_key = AppBKey;
        wait_ready(ok);
        if (!ok) timeout("b2b_accept0");
        @(posedge clk); #2;
        c0 = cyc; in_block = AppCPt; in_key = AppCKey;
        wait_ready(ok);
        if (!ok) timeout("b2b_accept1");
        @(posedge clk); #2;
        c1 = cyc; in_valid = 1'b0;
        chk("b2b_spacing", 128'(c1 - c0), 128'd12);
        for (int i = 0; i < 40 && sunk.size() < 2; i++) @(posedge clk);
        #2;
        chk("b2b_sunk_count", 128'(sunk.size()), 128'd2);
        if (sunk.size() == 2) begin
            chk("b2b_ct0", sunk[0], AppBCt);
            chk("b2b_ct1", sunk[1], AppCCt);
        end

        // One-edge reset while round_cnt is 5.
        sunk.delete();
        send(AppCPt, AppCKey, acc);
        wait_round(4'd4);
        @(posedge clk); #2 rst_n = 1'b0;
        @(posedge clk); #2 rst_n = 1'b1;
        @(negedge clk);
        chk("mrst_busy", 128'(busy), 128'd0);
        chk("mrst_out_valid", 128'(out_valid), 128'd0);
        chk("mrst_round_cnt", 128'(round_cnt), 128'd0);
        chk("mrst_in_ready", 128'(in_ready), 128'd1);
        send(AppBPt, AppBKey, acc);
        wait_out(ct, lat);
        chk("mrst_appB_ct", ct, AppBCt);
        @(posedge clk); #2;
        chk("mrst_sunk_count", 128'(sunk.size()), 128'd1);

`ifdef AES_CTRL_ABORT_EN
        // Abort while round_cnt is 3.
        sunk.delete();
        send(AppBPt, AppBKey, acc);
        wait_round(4'd2);
        @(posedge clk); #2 abort = 1'b1;
        @(posedge clk); #2 abort = 1'b0;
        @(negedge clk);
        chk("abort_in_ready", 128'(in_ready), 128'd1);
        chk("abort_out_valid", 128'(out_valid), 128'd0);
        chk("abort_round_cnt", 128'(round_cnt), 128'd0);
        send(AppCPt, AppCKey, acc);
        wait_out(ct, lat);
        chk("abort_appC_ct", ct, AppCCt);
        @(posedge clk); #2;
        chk("abort_sunk_count", 128'(sunk.size()), 128'd1);
`endif

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
